// File: rtl/shim_cfg_sync_pkg.sv
// Shared types and helpers for the shim configuration synchroniser bank.
package shim_cfg_sync_pkg;

  // Per-lane acceptance state: waiting for a change, filtering, or holding a word for commit.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    PENDING  = 2'd2
  } syncState_t;

  // A single flop gives no metastability protection, so two stages is the floor.
  localparam int SYNC_STAGES_MIN = 2;

  // The stability counter must be able to represent values up to stableCycles.
  function automatic int cntWidth(input int stableCycles);
    return $clog2(stableCycles + 1);
  endfunction

endpackage

// File: rtl/shim_cfg_sync_lane.sv
// One configuration channel: bit-wise synchroniser, stability filter,
// and a safe-point gated whole-word commit into the output register.
module shim_cfg_sync_lane
  import shim_cfg_sync_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] DEFAULT       = '0,
  parameter bit               GATED         = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_apply_ok,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_upd,
  output logic             o_pending
);

  localparam int             CW       = cntWidth(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Reject configurations that would make the synchroniser or filter meaningless.
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_badSyncStages
    $error("shim_cfg_sync_lane: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1) begin : g_badStableCycles
    $error("shim_cfg_sync_lane: STABLE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_cnt;
  syncState_t       r_state;
  logic             r_upd;
  logic             r_pending;

  logic [WIDTH-1:0] w_s;
  logic             w_change;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_change = (w_s != r_prev);

  // Per-bit synchroniser chain; bits may resolve on different cycles, which the filter absorbs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= DEFAULT;
      end
    end else begin
      r_sync[0] <= i_din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Acceptance FSM: a word must hold still for STABLE_CYCLES before it may be committed whole.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= DEFAULT;
      r_pend    <= DEFAULT;
      r_dout    <= DEFAULT;
      r_cnt     <= '0;
      r_state   <= IDLE;
      r_upd     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_change) begin
            r_prev  <= w_s;
            r_cnt   <= '0;
            r_state <= SETTLING;
          end
        end
        SETTLING: begin
          if (w_change) begin
            r_prev <= w_s;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            if (w_s == r_dout) begin
              r_state <= IDLE;
            end else begin
              r_pend    <= w_s;
              r_pending <= 1'b1;
              r_state   <= PENDING;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PENDING: begin
          if (w_change) begin
            r_prev    <= w_s;
            r_cnt     <= '0;
            r_pend    <= r_dout;
            r_pending <= 1'b0;
            r_state   <= SETTLING;
          end else if (i_apply_ok || !GATED) begin
            r_dout    <= r_pend;
            r_upd     <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_pending <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign o_dout    = r_dout;
  assign o_upd     = r_upd;
  assign o_pending = r_pending;

endmodule

// File: rtl/shim_cfg_sync_bank.sv
// Bank of independent configuration synchroniser lanes sharing one safe-point qualifier.
module shim_cfg_sync_bank
  import shim_cfg_sync_pkg::*;
#(
  parameter int                    N_CH          = 4,
  parameter int                    WIDTH         = 32,
  parameter int                    SYNC_STAGES   = 2,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [N_CH*WIDTH-1:0] DEFAULTS      = '0,
  parameter logic [N_CH-1:0]       GATED         = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic                  apply_ok,
  output logic [N_CH*WIDTH-1:0] dout,
  output logic [N_CH-1:0]       upd,
  output logic [N_CH-1:0]       pending
);

  // Guard the bank-level stage count as well so a bad override fails at the top.
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_badBankStages
    $error("shim_cfg_sync_bank: SYNC_STAGES must be at least 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    shim_cfg_sync_lane #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .DEFAULT      (DEFAULTS[i*WIDTH +: WIDTH]),
      .GATED        (GATED[i])
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_din     (din[i*WIDTH +: WIDTH]),
      .i_apply_ok(apply_ok),
      .o_dout    (dout[i*WIDTH +: WIDTH]),
      .o_upd     (upd[i]),
      .o_pending (pending[i])
    );
  end

endmodule

// File: tb/tb_shim_cfg_sync_bank.sv
// Directed self-checking bench for the configuration synchroniser bank.
module tb_shim_cfg_sync_bank;

  localparam int           N_CH     = 4;
  localparam int           WIDTH    = 32;
  localparam logic [127:0] DEFAULTS = {32'h0, 32'h0, 32'h0, 32'h00010000};
  localparam logic [3:0]   GATED    = 4'b0111;

  logic         clk;
  logic         reset;
  logic [127:0] din;
  logic         apply_ok;
  logic [127:0] dout;
  logic [3:0]   upd;
  logic [3:0]   pending;

  int checkCount = 0;
  int failCount  = 0;
  int updCount [N_CH];
  int updBase;

  shim_cfg_sync_bank #(
    .N_CH         (N_CH),
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .DEFAULTS     (DEFAULTS),
    .GATED        (GATED)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .apply_ok(apply_ok),
    .dout    (dout),
    .upd     (upd),
    .pending (pending)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tally every upd pulse per channel, sampled mid-cycle.
  initial begin
    for (int i = 0; i < N_CH; i++) updCount[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        if (upd[i] === 1'b1) updCount[i]++;
      end
    end
  end

  function automatic logic [31:0] doutCh(input int ch);
    return dout[ch*32 +: 32];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [31:0] value);
    din[ch*32 +: 32] = value;
  endtask

  // Advance n active edges, returning just after the last one.
  task automatic stepClocks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    apply_ok = 1'b1;
    din      = '0;
    applyStimulus(0, 32'h00010000);

    // Reset state
    #2;
    checkOutput("rst_dout0", doutCh(0), 32'h00010000);
    checkOutput("rst_upd", {28'h0, upd}, 32'h0);
    checkOutput("rst_pending", {28'h0, pending}, 32'h0);
    stepClocks(3);
    reset = 1'b0;
    stepClocks(12);
    checkOutput("post_rst_dout0", doutCh(0), 32'h00010000);
    checkOutput("post_rst_dout1", doutCh(1), 32'h0);
    checkOutput("post_rst_upd0_count", updCount[0], 32'd0);
    checkOutput("post_rst_pending", {28'h0, pending}, 32'h0);

    // Clean step on ch1, latency 8, no intermediate value
    applyStimulus(1, 32'hDEADBEEF);
    for (int e = 1; e <= 8; e++) begin
      stepClocks(1);
      if (e < 8) checkOutput($sformatf("step1_hold_e%0d", e), doutCh(1), 32'h0);
      else       checkOutput("step1_commit", doutCh(1), 32'hDEADBEEF);
    end
    checkOutput("step1_upd_at8", {31'h0, upd[1]}, 32'h1);
    stepClocks(1);
    checkOutput("step1_upd_after", {31'h0, upd[1]}, 32'h0);
    checkOutput("step1_upd_count", updCount[1], 32'd1);

    // Ungated ch3 commits with apply_ok low
    apply_ok = 1'b0;
    applyStimulus(3, 32'hA5A5A5A5);
    stepClocks(7);
    checkOutput("ungated_hold", doutCh(3), 32'h0);
    stepClocks(1);
    checkOutput("ungated_commit", doutCh(3), 32'hA5A5A5A5);
    checkOutput("ungated_upd", {31'h0, upd[3]}, 32'h1);
    apply_ok = 1'b1;

    // ch2 toggling faster than the stability window never commits
    for (int t = 0; t < 5; t++) begin
      applyStimulus(2, (t % 2 == 0) ? 32'h1 : 32'h2);
      stepClocks(3);
    end
    checkOutput("toggle_dout", doutCh(2), 32'h0);
    checkOutput("toggle_upd_count", updCount[2], 32'd0);
    applyStimulus(2, 32'h2);
    stepClocks(7);
    checkOutput("toggle_settle_hold", doutCh(2), 32'h0);
    stepClocks(1);
    checkOutput("toggle_settle_commit", doutCh(2), 32'h2);
    stepClocks(2);
    checkOutput("toggle_upd_once", updCount[2], 32'd1);

    // Gated hold with apply_ok low, then release
    applyStimulus(0, 32'h0);
    stepClocks(10);
    checkOutput("ch0_zero", doutCh(0), 32'h0);
    apply_ok = 1'b0;
    applyStimulus(0, 32'h5);
    stepClocks(100);
    checkOutput("gated_pending", {31'h0, pending[0]}, 32'h1);
    checkOutput("gated_dout_held", doutCh(0), 32'h0);
    apply_ok = 1'b1;
    stepClocks(1);
    checkOutput("gated_commit", doutCh(0), 32'h5);
    checkOutput("gated_upd", {31'h0, upd[0]}, 32'h1);
    checkOutput("gated_pending_clr", {31'h0, pending[0]}, 32'h0);

    // Revert to current dout while pending: no update
    applyStimulus(0, 32'h0);
    stepClocks(10);
    checkOutput("revert_base", doutCh(0), 32'h0);
    apply_ok = 1'b0;
    applyStimulus(0, 32'h5);
    stepClocks(10);
    checkOutput("revert_pending", {31'h0, pending[0]}, 32'h1);
    updBase = updCount[0];
    applyStimulus(0, 32'h0);
    stepClocks(10);
    checkOutput("revert_pending_clr", {31'h0, pending[0]}, 32'h0);
    checkOutput("revert_dout", doutCh(0), 32'h0);
    checkOutput("revert_no_upd", updCount[0], updBase);

    // Change coinciding with apply_ok: change wins
    applyStimulus(0, 32'h5);
    stepClocks(10);
    checkOutput("race_pending", {31'h0, pending[0]}, 32'h1);
    applyStimulus(0, 32'h7);
    stepClocks(2);
    apply_ok = 1'b1;
    stepClocks(1);
    checkOutput("race_no_commit", doutCh(0), 32'h0);
    checkOutput("race_no_upd", {31'h0, upd[0]}, 32'h0);
    checkOutput("race_pending_clr", {31'h0, pending[0]}, 32'h0);
    stepClocks(6);
    checkOutput("race_later_commit", doutCh(0), 32'h7);

    // Async reset mid-SETTLING
    applyStimulus(1, 32'h12345678);
    stepClocks(4);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_settle_dout1", doutCh(1), 32'h0);
    checkOutput("arst_settle_dout0", doutCh(0), 32'h00010000);
    checkOutput("arst_settle_pending", {28'h0, pending}, 32'h0);
    stepClocks(1);
    reset    = 1'b0;
    apply_ok = 1'b0;

    // Async reset mid-PENDING
    stepClocks(10);
    checkOutput("arst_pend_before", {31'h0, pending[0]}, 32'h1);
    checkOutput("arst_ch3_committed", doutCh(3), 32'hA5A5A5A5);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_pend_dout0", doutCh(0), 32'h00010000);
    checkOutput("arst_pend_dout3", doutCh(3), 32'h0);
    checkOutput("arst_pend_pending", {28'h0, pending}, 32'h0);
    checkOutput("arst_pend_upd", {28'h0, upd}, 32'h0);
    stepClocks(1);
    reset = 1'b0;

    // Ungated lane commits at latency 8 after reset without apply_ok
    stepClocks(7);
    checkOutput("ungated_rst_hold", doutCh(3), 32'h0);
    stepClocks(1);
    checkOutput("ungated_rst_commit", doutCh(3), 32'hA5A5A5A5);
    checkOutput("ungated_rst_upd", {31'h0, upd[3]}, 32'h1);
    checkOutput("gated_ch0_held", doutCh(0), 32'h00010000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
